// File: rtl/ysyx_22050550_fwd_scoreboard.sv
// rtl/ysyx_22050550_fwd_scoreboard.sv - operand forwarding, register scoreboard and IDU stall generation
module ysyx_22050550_fwd_scoreboard #(
    parameter int XLEN   = 64,
    parameter int RAW    = 5,
    parameter int NFWD   = 3,
    parameter bit FWD_EN = 1'b1,
    parameter int CW     = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 io_IDU_valid,
    input  logic [RAW-1:0]       io_IDU_raddr1,
    input  logic [RAW-1:0]       io_IDU_raddr2,
    input  logic                 io_IDU_ren1,
    input  logic                 io_IDU_ren2,
    input  logic [XLEN-1:0]      io_RF_rdata1,
    input  logic [XLEN-1:0]      io_RF_rdata2,
    output logic [XLEN-1:0]      io_IDU_rdata1,
    output logic [XLEN-1:0]      io_IDU_rdata2,
    output logic                 io_IDU_pass1,
    output logic                 io_IDU_pass2,
    output logic                 io_IDU_stall,
    input  logic                 io_iss_fire,
    input  logic                 io_iss_wen,
    input  logic [RAW-1:0]       io_iss_waddr,
    input  logic [NFWD-1:0]      io_fwd_valid,
    input  logic [NFWD-1:0]      io_fwd_ready,
    input  logic [NFWD*RAW-1:0]  io_fwd_waddr,
    input  logic [NFWD*XLEN-1:0] io_fwd_wdata,
    input  logic                 io_cmt_valid,
    input  logic [RAW-1:0]       io_cmt_waddr,
    input  logic                 io_flush,
    output logic [31:0]          io_stall_cnt
);
    localparam int NREG = 1 << RAW;

    logic [CW-1:0] cnt_q [NREG];
    logic [CW-1:0] cnt_d [NREG];
    logic [31:0]   stall_cnt_q;
    logic [31:0]   stall_cnt_d;

    logic [1:0][RAW-1:0]  raddr;
    logic [1:0]           ren;
    logic [1:0][XLEN-1:0] rf_data;
    logic [1:0][XLEN-1:0] rdata;
    logic [1:0]           pass;
    logic [1:0]           hazard;

    assign raddr   = {io_IDU_raddr2, io_IDU_raddr1};
    assign ren     = {io_IDU_ren2, io_IDU_ren1};
    assign rf_data = {io_RF_rdata2, io_RF_rdata1};

    for (genvar i = 0; i < 2; i++) begin : g_src
        logic            hit;
        logic            hit_ready;
        logic [XLEN-1:0] hit_data;
        logic            use_fwd;
        logic            busy;

        // Scan oldest to youngest so the youngest matching stage overrides.
        always_comb begin
            hit       = 1'b0;
            hit_ready = 1'b0;
            hit_data  = '0;
            for (int s = NFWD - 1; s >= 0; s--) begin
                if (io_fwd_valid[s] && io_fwd_waddr[s*RAW +: RAW] == raddr[i] && raddr[i] != '0) begin
                    hit       = 1'b1;
                    hit_ready = io_fwd_ready[s];
                    hit_data  = io_fwd_wdata[s*XLEN +: XLEN];
                end
            end
        end

        assign use_fwd   = FWD_EN && hit && hit_ready;
        assign busy      = ren[i] && raddr[i] != '0 && cnt_q[raddr[i]] != '0;
        assign hazard[i] = busy && !use_fwd;
        assign pass[i]   = reset && io_IDU_valid && use_fwd;
        assign rdata[i]  = (reset && use_fwd) ? hit_data : rf_data[i];
    end

    assign io_IDU_rdata1 = rdata[0];
    assign io_IDU_rdata2 = rdata[1];
    assign io_IDU_pass1  = pass[0];
    assign io_IDU_pass2  = pass[1];
    assign io_IDU_stall  = reset && io_IDU_valid && (|hazard);
    assign io_stall_cnt  = stall_cnt_q;

    // Simultaneous issue and commit to the same register cancel out.
    always_comb begin
        logic inc;
        logic dec;
        inc = 1'b0;
        dec = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            inc      = io_iss_fire && io_iss_wen && io_iss_waddr == RAW'(r);
            dec      = io_cmt_valid && io_cmt_waddr == RAW'(r);
            cnt_d[r] = cnt_q[r];
            if (r == 0 || io_flush) begin
                cnt_d[r] = '0;
            end else if (inc && !dec && cnt_q[r] != '1) begin
                cnt_d[r] = cnt_q[r] + CW'(1);
            end else if (dec && !inc && cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - CW'(1);
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (io_IDU_stall && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_ysyx_22050550_fwd_scoreboard.sv
// tb/tb_ysyx_22050550_fwd_scoreboard.sv - scoreboard bench for forwarding unit, FWD_EN=1 and FWD_EN=0 instances
module tb_ysyx_22050550_fwd_scoreboard;
    localparam int XLEN = 64;
    localparam int RAW  = 5;
    localparam int NFWD = 3;
    localparam logic [63:0] RF1 = 64'h0000_0000_1111_1111;
    localparam logic [63:0] RF2 = 64'h0000_0000_2222_2222;

    logic clock = 1'b1;
    logic reset;
    logic valid, ren1, ren2, fire, iwen, cv, flush;
    logic [RAW-1:0] ra1, ra2, iwaddr, cwa;
    logic [XLEN-1:0] rf1, rf2;
    logic [NFWD-1:0] fv, fr;
    logic [NFWD*RAW-1:0] fwa;
    logic [NFWD*XLEN-1:0] fwd;

    logic [XLEN-1:0] d_rd1, d_rd2, z_rd1, z_rd2;
    logic d_p1, d_p2, d_st, z_p1, z_p2, z_st;
    logic [31:0] d_sc, z_sc;

    always #5 clock = ~clock;

    ysyx_22050550_fwd_scoreboard #(.XLEN(XLEN), .RAW(RAW), .NFWD(NFWD), .FWD_EN(1'b1), .CW(2)) dut (
        .clock(clock), .reset(reset), .io_IDU_valid(valid),
        .io_IDU_raddr1(ra1), .io_IDU_raddr2(ra2), .io_IDU_ren1(ren1), .io_IDU_ren2(ren2),
        .io_RF_rdata1(rf1), .io_RF_rdata2(rf2),
        .io_IDU_rdata1(d_rd1), .io_IDU_rdata2(d_rd2), .io_IDU_pass1(d_p1), .io_IDU_pass2(d_p2),
        .io_IDU_stall(d_st), .io_iss_fire(fire), .io_iss_wen(iwen), .io_iss_waddr(iwaddr),
        .io_fwd_valid(fv), .io_fwd_ready(fr), .io_fwd_waddr(fwa), .io_fwd_wdata(fwd),
        .io_cmt_valid(cv), .io_cmt_waddr(cwa), .io_flush(flush), .io_stall_cnt(d_sc)
    );

    ysyx_22050550_fwd_scoreboard #(.XLEN(XLEN), .RAW(RAW), .NFWD(NFWD), .FWD_EN(1'b0), .CW(2)) dut0 (
        .clock(clock), .reset(reset), .io_IDU_valid(valid),
        .io_IDU_raddr1(ra1), .io_IDU_raddr2(ra2), .io_IDU_ren1(ren1), .io_IDU_ren2(ren2),
        .io_RF_rdata1(rf1), .io_RF_rdata2(rf2),
        .io_IDU_rdata1(z_rd1), .io_IDU_rdata2(z_rd2), .io_IDU_pass1(z_p1), .io_IDU_pass2(z_p2),
        .io_IDU_stall(z_st), .io_iss_fire(fire), .io_iss_wen(iwen), .io_iss_waddr(iwaddr),
        .io_fwd_valid(fv), .io_fwd_ready(fr), .io_fwd_waddr(fwa), .io_fwd_wdata(fwd),
        .io_cmt_valid(cv), .io_cmt_waddr(cwa), .io_flush(flush), .io_stall_cnt(z_sc)
    );

    typedef struct {
        string       name;
        bit          nofwd;
        logic [63:0] rd1;
        bit          p1;
        logic [63:0] rd2;
        bit          p2;
        bit          st;
        bit          chk_sc;
        logic [31:0] sc;
    } exp_t;

    exp_t exp_q[$];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic expect_out(input string n, input bit w, input logic [63:0] a, input bit pa,
                              input logic [63:0] b, input bit pb, input bit st,
                              input bit cs, input logic [31:0] sc);
        exp_t e;
        e.name = n; e.nofwd = w; e.rd1 = a; e.p1 = pa; e.rd2 = b; e.p2 = pb;
        e.st = st; e.chk_sc = cs; e.sc = sc;
        exp_q.push_back(e);
    endtask

    always @(negedge clock) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [63:0] a1, a2;
            logic ap1, ap2, ast;
            logic [31:0] asc;
            bit ok;
            e   = exp_q.pop_front();
            a1  = e.nofwd ? z_rd1 : d_rd1;
            a2  = e.nofwd ? z_rd2 : d_rd2;
            ap1 = e.nofwd ? z_p1  : d_p1;
            ap2 = e.nofwd ? z_p2  : d_p2;
            ast = e.nofwd ? z_st  : d_st;
            asc = e.nofwd ? z_sc  : d_sc;
            ok  = (a1 === e.rd1) && (ap1 === e.p1) && (a2 === e.rd2) && (ap2 === e.p2) &&
                  (ast === e.st) && (!e.chk_sc || asc === e.sc);
            n_chk++;
            if (!ok) begin
                n_fail++;
                $display("FAIL %s: got rd1=%h p1=%b rd2=%h p2=%b stall=%b cnt=%0d, want rd1=%h p1=%b rd2=%h p2=%b stall=%b cnt=%0d(chk=%b)",
                         e.name, a1, ap1, a2, ap2, ast, asc, e.rd1, e.p1, e.rd2, e.p2, e.st, e.sc, e.chk_sc);
            end
        end
    end

    task automatic idle();
        valid = 0; ren1 = 0; ren2 = 0; ra1 = '0; ra2 = '0;
        rf1 = RF1; rf2 = RF2;
        fire = 0; iwen = 0; iwaddr = '0;
        fv = '0; fr = '0; fwa = '0; fwd = '0;
        cv = 0; cwa = '0; flush = 0;
    endtask

    task automatic stg(input int s, input bit rdy, input logic [RAW-1:0] a, input logic [63:0] d);
        fv[s] = 1'b1;
        fr[s] = rdy;
        fwa[s*RAW +: RAW] = a;
        fwd[s*XLEN +: XLEN] = d;
    endtask

    task automatic issue(input logic [RAW-1:0] a);
        fire = 1; iwen = 1; iwaddr = a;
    endtask

    task automatic commit(input logic [RAW-1:0] a);
        cv = 1; cwa = a;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 0;
        idle();
        valid = 1; ren1 = 1; ra1 = 5; stg(0, 1, 5, 64'h55);
        expect_out("reset_state", 0, RF1, 0, RF2, 0, 0, 1, 0);
        expect_out("reset_state_nofwd", 1, RF1, 0, RF2, 0, 0, 1, 0);
        tick();

        reset = 1;
        idle(); issue(5);
        expect_out("issue_idle", 0, RF1, 0, RF2, 0, 0, 1, 0);
        tick();

        idle(); valid = 1; ren1 = 1; ra1 = 5; stg(0, 1, 5, 64'h11);
        expect_out("fwd_exu", 0, 64'h11, 1, RF2, 0, 0, 0, 0);
        tick();

        idle(); valid = 1; ren1 = 1; ra1 = 5; stg(0, 1, 5, 64'hAA); stg(2, 1, 5, 64'hBB); commit(5);
        expect_out("youngest_wins", 0, 64'hAA, 1, RF2, 0, 0, 0, 0);
        tick();

        idle(); valid = 1; ren1 = 1; ra1 = 5; stg(1, 1, 5, 64'hCC); stg(2, 1, 5, 64'hBB);
        expect_out("mid_over_wbu", 0, 64'hCC, 1, RF2, 0, 0, 0, 0);
        expect_out("nofwd_x5_clear", 1, RF1, 0, RF2, 0, 0, 1, 2);
        tick();

        idle(); issue(7);
        tick();

        idle(); valid = 1; ren2 = 1; ra2 = 7; stg(0, 0, 7, 64'hDEAD);
        expect_out("load_stall", 0, RF1, 0, RF2, 0, 1, 1, 0);
        tick();

        idle(); valid = 1; ren2 = 1; ra2 = 7; stg(1, 1, 7, 64'h42);
        expect_out("load_ready", 0, RF1, 0, 64'h42, 1, 0, 1, 1);
        tick();

        idle(); commit(7);
        tick();

        idle(); valid = 1; ren1 = 1; ren2 = 1; stg(0, 1, 0, 64'hFF); issue(0);
        expect_out("x0_no_forward", 0, RF1, 0, RF2, 0, 0, 0, 0);
        tick();

        idle(); valid = 1; ren1 = 1; ren2 = 1; ra2 = 7;
        expect_out("x0_never_busy", 0, RF1, 0, RF2, 0, 0, 0, 0);
        tick();

        idle(); issue(3); tick();
        idle(); issue(3); tick();
        idle(); commit(3); tick();

        idle(); valid = 1; ren1 = 1; ra1 = 3;
        expect_out("cnt3_after_two_one", 0, RF1, 0, RF2, 0, 1, 1, 1);
        tick();

        idle(); valid = 1; ren1 = 1; ra1 = 3; issue(3); commit(3);
        expect_out("issue_commit_same", 0, RF1, 0, RF2, 0, 1, 1, 2);
        tick();

        idle(); valid = 1; ren1 = 1; ra1 = 3; flush = 1;
        expect_out("cnt3_unchanged", 0, RF1, 0, RF2, 0, 1, 1, 3);
        tick();

        idle(); valid = 1; ren1 = 1; ra1 = 3;
        expect_out("post_flush", 0, RF1, 0, RF2, 0, 0, 1, 4);
        tick();

        for (int k = 0; k < 4; k++) begin
            idle(); issue(4); tick();
        end

        idle(); valid = 1; ren1 = 1; ra1 = 4;
        expect_out("saturate_hold", 0, RF1, 0, RF2, 0, 1, 1, 4);
        tick();

        idle(); valid = 1; ra1 = 4;
        expect_out("ren_off", 0, RF1, 0, RF2, 0, 0, 1, 5);
        tick();

        for (int k = 0; k < 3; k++) begin
            idle(); commit(4); tick();
        end

        idle(); valid = 1; ren1 = 1; ra1 = 4;
        expect_out("saturate_drain", 0, RF1, 0, RF2, 0, 0, 1, 5);
        tick();

        idle(); commit(6); tick();

        idle(); valid = 1; ren2 = 1; ra2 = 6;
        expect_out("floor_zero", 0, RF1, 0, RF2, 0, 0, 0, 0);
        tick();

        idle(); issue(9); tick();

        idle(); valid = 1; ren1 = 1; ra1 = 9; stg(0, 1, 9, 64'h99);
        expect_out("nofwd_stall", 1, RF1, 0, RF2, 0, 1, 0, 0);
        expect_out("fwd_x9", 0, 64'h99, 1, RF2, 0, 0, 0, 0);
        tick();

        idle(); valid = 1; ren1 = 1; ra1 = 9; stg(0, 1, 9, 64'h99); commit(9);
        expect_out("nofwd_commit_cycle", 1, RF1, 0, RF2, 0, 1, 0, 0);
        tick();

        idle(); valid = 1; ren1 = 1; ra1 = 9; stg(0, 1, 9, 64'h99);
        expect_out("nofwd_released", 1, RF1, 0, RF2, 0, 0, 1, 10);
        tick();

        idle(); issue(9); tick();

        idle(); valid = 1; ren1 = 1; ra1 = 9;
        expect_out("nofwd_busy9", 1, RF1, 0, RF2, 0, 1, 0, 0);
        tick();

        reset = 0;
        idle(); valid = 1; ren1 = 1; ra1 = 9; stg(0, 1, 9, 64'h99);
        expect_out("reset_mid_nofwd", 1, RF1, 0, RF2, 0, 0, 1, 0);
        expect_out("reset_mid_fwd", 0, RF1, 0, RF2, 0, 0, 1, 0);
        tick();

        reset = 1;
        idle(); valid = 1; ren1 = 1; ra1 = 9;
        expect_out("reset_cleared_nofwd", 1, RF1, 0, RF2, 0, 0, 1, 0);
        expect_out("reset_cleared_fwd", 0, RF1, 0, RF2, 0, 0, 1, 0);
        tick();

        @(negedge clock);
        #1;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
